// File: rtl/imem_loader_if.sv
// Loader-side bus: byte stream in, instruction-memory write port and status out.
interface imem_loader_if #(
    parameter int unsigned INS_ADDRESS = 32,
    parameter int unsigned INS_W       = 32
);
    logic                   load_req;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic                   mem_we;
    logic [INS_ADDRESS-1:0] mem_waddr;
    logic [INS_W-1:0]       mem_wdata;
    logic                   cpu_hold;
    logic                   load_done;
    logic                   load_error;
    logic [15:0]            word_count;

    modport master (
        output load_req, rx_data, rx_valid,
        input  rx_ready, mem_we, mem_waddr, mem_wdata,
        input  cpu_hold, load_done, load_error, word_count
    );

    modport slave (
        input  load_req, rx_data, rx_valid,
        output rx_ready, mem_we, mem_waddr, mem_wdata,
        output cpu_hold, load_done, load_error, word_count
    );
endinterface

// File: rtl/imem_loader.sv
// Fills instruction memory from a little-endian byte stream (16-bit word-count
// header, then 4 bytes per word) while holding the processor.
module imem_loader #(
    parameter int unsigned INS_ADDRESS = 32,
    parameter int unsigned INS_W       = 32,
    parameter int unsigned MAX_WORDS   = 16
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam int unsigned WC_W = 16;

    localparam logic [2:0] S_RUN   = 3'd0;
    localparam logic [2:0] S_HDR0  = 3'd1;
    localparam logic [2:0] S_HDR1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    logic [2:0]             r_state;
    logic [2:0]             w_state_nxt;
    logic                   r_rx_ready;
    logic                   r_mem_we;
    logic [INS_ADDRESS-1:0] r_mem_waddr;
    logic [INS_W-1:0]       r_mem_wdata;
    logic                   r_cpu_hold;
    logic                   r_load_done;
    logic                   r_load_error;
    logic [WC_W-1:0]        r_word_count;
    logic [WC_W-1:0]        r_words_written;
    logic [1:0]             r_byte_idx;
    logic [23:0]            r_word;
    logic                   w_accept;
    logic [WC_W-1:0]        w_hdr_count;

    assign w_accept    = bus.rx_valid & r_rx_ready;
    assign w_hdr_count = {bus.rx_data, r_word_count[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (bus.load_req) w_state_nxt = S_HDR0;
            S_HDR0:  if (w_accept) w_state_nxt = S_HDR1;
            S_HDR1: begin
                if (w_accept) begin
                    if (w_hdr_count == WC_W'(0))              w_state_nxt = S_DONE;
                    else if (w_hdr_count > WC_W'(MAX_WORDS))  w_state_nxt = S_ERROR;
                    else                                      w_state_nxt = S_DATA;
                end
            end
            S_DATA:  if (w_accept && r_byte_idx == 2'd3) w_state_nxt = S_WRITE;
            S_WRITE: begin
                if (r_words_written + WC_W'(1) == r_word_count) w_state_nxt = S_DONE;
                else                                            w_state_nxt = S_DATA;
            end
            S_DONE:  w_state_nxt = S_RUN;
            S_ERROR: if (bus.load_req) w_state_nxt = S_HDR0;
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Status outputs are registered decodes of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_ready   <= 1'b0;
            r_cpu_hold   <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
            r_mem_we     <= 1'b0;
        end else begin
            r_rx_ready   <= (w_state_nxt == S_HDR0) || (w_state_nxt == S_HDR1) ||
                            (w_state_nxt == S_DATA);
            r_cpu_hold   <= (w_state_nxt != S_RUN);
            r_load_done  <= (w_state_nxt == S_DONE);
            r_load_error <= (w_state_nxt == S_ERROR);
            r_mem_we     <= (w_state_nxt == S_WRITE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_count    <= '0;
            r_words_written <= '0;
            r_byte_idx      <= '0;
            r_word          <= '0;
            r_mem_waddr     <= '0;
            r_mem_wdata     <= '0;
        end else begin
            case (r_state)
                S_RUN, S_ERROR: begin
                    r_words_written <= '0;
                    r_byte_idx      <= '0;
                end
                S_HDR0: if (w_accept) r_word_count[7:0]  <= bus.rx_data;
                S_HDR1: if (w_accept) r_word_count[15:8] <= bus.rx_data;
                S_DATA: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= bus.rx_data;
                            2'd1: r_word[15:8]  <= bus.rx_data;
                            2'd2: r_word[23:16] <= bus.rx_data;
                            default: begin
                                // Final byte goes straight into the write register.
                                r_mem_wdata <= INS_W'({bus.rx_data, r_word});
                                r_mem_waddr <= INS_ADDRESS'({r_words_written, 2'b00});
                            end
                        endcase
                    end
                end
                S_WRITE: r_words_written <= r_words_written + WC_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_waddr  = r_mem_waddr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.load_done  = r_load_done;
    assign bus.load_error = r_load_error;
    assign bus.word_count = r_word_count;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as bytes are
// streamed and checked against every mem_we cycle.
module tb_imem_loader;
    localparam int unsigned INS_ADDRESS = 32;
    localparam int unsigned INS_W       = 32;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    wr_t  exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imem_loader_if #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) bus ();

    imem_loader #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W), .MAX_WORDS(16)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_req();
        bus.load_req = 1'b1;
        @(negedge clk);
        bus.load_req = 1'b0;
    endtask

    // Present one byte after a gap and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        acc = 1'b0;
        repeat (gap) begin
            bus.rx_valid = 1'b0;
            @(negedge clk);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int t = 0; t < 32 && !acc; t++) begin
            acc = bus.rx_ready;
            @(negedge clk);
        end
        chk("byte_accept", 32'(acc), 32'd1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        while (bus.load_done !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("load_done_seen", 32'(bus.load_done), 32'd1);
    endtask

    task automatic push_two_words();
        exp_q.push_back('{addr: 32'h0, data: 32'h0010_0093});
        exp_q.push_back('{addr: 32'h4, data: 32'h0010_0113});
    endtask

    // Scoreboard: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(bus.mem_we), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", bus.mem_waddr, e.addr);
                chk("wr_data", bus.mem_wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] s2w[10];
        logic [7:0] s1w[6];
        s2w = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
        s1w = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};

        reset        = 1'b1;
        bus.load_req = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) tick();
        chk("rst_rx_ready",   32'(bus.rx_ready),   32'd0);
        chk("rst_cpu_hold",   32'(bus.cpu_hold),   32'd0);
        chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
        chk("rst_waddr",      bus.mem_waddr,       32'd0);
        chk("rst_wdata",      bus.mem_wdata,       32'd0);
        chk("rst_word_count", 32'(bus.word_count), 32'd0);
        reset = 1'b0;
        tick();
        chk("run_rx_ready", 32'(bus.rx_ready), 32'd0);

        // Two-word load with rx_valid held high.
        push_two_words();
        pulse_req();
        chk("t1_hold_after_req",  32'(bus.cpu_hold), 32'd1);
        chk("t1_ready_after_req", 32'(bus.rx_ready), 32'd1);
        for (int i = 0; i < 10; i++) send_byte(s2w[i], 0);
        chk("t1_last_write", 32'(bus.mem_we), 32'd1);
        tick();
        chk("t1_done",       32'(bus.load_done), 32'd1);
        chk("t1_hold_done",  32'(bus.cpu_hold),  32'd1);
        tick();
        chk("t1_done_pulse", 32'(bus.load_done), 32'd0);
        chk("t1_release",    32'(bus.cpu_hold),  32'd0);
        chk("t1_word_count", 32'(bus.word_count), 32'd2);
        chk("t1_q_empty",    32'(exp_q.size()),   32'd0);

        // Empty programme.
        pulse_req();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("t2_done",       32'(bus.load_done),  32'd1);
        chk("t2_no_write",   32'(bus.mem_we),     32'd0);
        chk("t2_word_count", 32'(bus.word_count), 32'd0);
        tick();
        chk("t2_done_pulse", 32'(bus.load_done), 32'd0);
        chk("t2_release",    32'(bus.cpu_hold),  32'd0);

        // Oversize header, then recovery with a one-word load.
        pulse_req();
        send_byte(8'h11, 0);
        send_byte(8'h00, 0);
        chk("t3_error",      32'(bus.load_error), 32'd1);
        chk("t3_hold",       32'(bus.cpu_hold),   32'd1);
        chk("t3_ready",      32'(bus.rx_ready),   32'd0);
        chk("t3_word_count", 32'(bus.word_count), 32'h11);
        bus.rx_data  = 8'hA5;
        bus.rx_valid = 1'b1;
        repeat (3) tick();
        bus.rx_valid = 1'b0;
        chk("t3_error_sticky", 32'(bus.load_error), 32'd1);
        chk("t3_ready_sticky", 32'(bus.rx_ready),   32'd0);
        exp_q.push_back('{addr: 32'h0, data: 32'h0000_0013});
        pulse_req();
        chk("t3_error_clear", 32'(bus.load_error), 32'd0);
        chk("t3_ready_again", 32'(bus.rx_ready),   32'd1);
        for (int i = 0; i < 6; i++) send_byte(s1w[i], 0);
        tick();
        chk("t3_done", 32'(bus.load_done), 32'd1);
        tick();
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

        // Flow control gaps; byte 6 is presented during the first WRITE.
        push_two_words();
        pulse_req();
        for (int i = 0; i < 10; i++) begin
            int g;
            g = (i == 6) ? 0 : int'($urandom_range(0, 3));
            send_byte(s2w[i], g);
        end
        wait_done(10);
        tick();
        chk("t4_release", 32'(bus.cpu_hold), 32'd0);
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of the third word.
        push_two_words();
        pulse_req();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 2; i < 10; i++) send_byte(s2w[i], 0);
        send_byte(8'hAA, 0);
        bus.rx_data  = 8'h55;
        bus.rx_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("t5_rx_ready",   32'(bus.rx_ready),   32'd0);
        chk("t5_cpu_hold",   32'(bus.cpu_hold),   32'd0);
        chk("t5_mem_we",     32'(bus.mem_we),     32'd0);
        chk("t5_waddr",      bus.mem_waddr,       32'd0);
        chk("t5_wdata",      bus.mem_wdata,       32'd0);
        chk("t5_word_count", 32'(bus.word_count), 32'd0);
        chk("t5_load_done",  32'(bus.load_done),  32'd0);
        chk("t5_load_error", 32'(bus.load_error), 32'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        bus.rx_valid = 1'b0;
        chk("t5_post_hold",  32'(bus.cpu_hold), 32'd0);
        chk("t5_post_ready", 32'(bus.rx_ready), 32'd0);
        chk("t5_q_empty",    32'(exp_q.size()), 32'd0);

        // load_req pulses during HDR1 and DATA must be ignored.
        push_two_words();
        pulse_req();
        send_byte(s2w[0], 0);
        bus.load_req = 1'b1;
        send_byte(s2w[1], 0);
        bus.load_req = 1'b0;
        send_byte(s2w[2], 0);
        bus.load_req = 1'b1;
        send_byte(s2w[3], 0);
        bus.load_req = 1'b0;
        for (int i = 4; i < 10; i++) send_byte(s2w[i], 0);
        wait_done(10);
        chk("t6_word_count", 32'(bus.word_count), 32'd2);
        tick();
        chk("t6_release", 32'(bus.cpu_hold), 32'd0);
        chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Sequencer that fills the instruction memory from a byte stream before the processor runs. It holds the processor (PC and register file) while loading and assembles little-endian bytes into 32-bit instructions. Each instruction is written at consecutive byte addresses 0, 4, 8, …, and the processor is released when the programme is complete. It sits between the debug/UART receiver and the instruction memory write port; the processor's fetch read path is unaffected.

## Interface
- INS_ADDRESS, 32, width of instruction memory address
- INS_W, 32, instruction width; fixed at 32 (4 bytes per word)
- MAX_WORDS, 16, maximum programme length in words; last legal address is 4*(MAX_WORDS-1)

- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- load_req  in  1  single-cycle request to start a load
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte; transfer = rx_valid & rx_ready
- mem_we  out  1  instruction memory write enable, one cycle per word
- mem_waddr  out  INS_ADDRESS  byte address of write
- mem_wdata  out  INS_W  assembled instruction
- cpu_hold  out  1  holds processor; PC restarts at 0 on release
- load_done  out  1  one-cycle pulse on successful load
- load_error  out  1  sticky; set on oversize header, cleared by next accepted load_req
- word_count  out  16  header word count of current/last load

## Operation
- States: RUN, HDR0, HDR1, DATA, WRITE, DONE, ERROR. Reset → RUN.
- RUN:
  - cpu_hold=0, rx_ready=0.
  - load_req → HDR0.
  - Clear the word counter, byte index and load_error.
- HDR0:
  - cpu_hold=1, rx_ready=1.
  - The accepted byte becomes word_count[7:0]; → HDR1.
- HDR1:
  - rx_ready=1.
  - The accepted byte becomes word_count[15:8]. The full count {byte, word_count[7:0]} decides the next state:
    - count 0 → DONE;
    - count > MAX_WORDS → ERROR;
    - otherwise → DATA.
- DATA:
  - rx_ready=1.
  - Byte index 0..3 places the byte at bits [8*i+7:8*i]; first byte is the LSB.
  - On acceptance of byte index 3 → WRITE; index wraps to 0.
- WRITE:
  - One cycle; rx_ready=0, mem_we=1.
  - mem_waddr = 4*words_written, zero-extended to INS_ADDRESS; mem_wdata = assembled word.
  - Increment words_written.
  - If words_written+1 == word_count → DONE, else → DATA.
- DONE:
  - One cycle; load_done=1, cpu_hold=1, rx_ready=0; → RUN.
- ERROR:
  - cpu_hold=1, load_error=1, rx_ready=0, no writes.
  - load_req → HDR0.
- load_req is ignored in HDR0, HDR1, DATA, WRITE and DONE.
- Arithmetic:
  - words_written is 16 bits and never exceeds MAX_WORDS.
  - Address = words_written<<2, so it never exceeds 4*(MAX_WORDS-1).
- mem_waddr and mem_wdata hold their last values when mem_we=0.

## Timing
- Reset values:
  - state RUN;
  - rx_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0;
  - cpu_hold 0, load_done 0, load_error 0, word_count 0.
- Reset mid-load aborts immediately. Memory contents are left partially written, and the processor runs from PC 0.
- load_req sampled in cycle N → cpu_hold=1 and rx_ready=1 from N+1.
- The 4th byte of a word accepted in cycle N → mem_we in N+1. The next byte is acceptable from N+2.
- The last WRITE in cycle N → load_done in N+1 → cpu_hold=0 from N+2.
- With count 0, HDR1 acceptance in N → load_done in N+1.
- Minimum load time: 2 + 5*count + 1 cycles after load_req, with rx_valid held high.
- rx_valid may drop at any point; the byte index and partial word are retained indefinitely.
- A byte is never consumed twice: in WRITE, rx_ready=0 and the presented byte stays pending.

## Test plan
- Load two words: reset, then load_req, then stream 02 00 93 00 10 00 13 01 10 00 with rx_valid held high.
  - Required writes: (addr 0x0, 0x00100093) and (addr 0x4, 0x00100113), one mem_we cycle each.
  - Then load_done for one cycle, and cpu_hold=0 one cycle later.
- Empty programme: load_req, then stream 00 00.
  - No mem_we; load_done exactly one cycle after the second byte; word_count=0.
- Oversize programme: load_req, then stream 11 00 (17 > 16).
  - ERROR state: load_error=1, cpu_hold=1, rx_ready=0, no writes.
  - A subsequent load_req plus a valid 01 00 13 00 00 00 clears load_error and writes (0x0, 0x00000013).
- Flow control: insert rx_valid gaps of 0–3 cycles between bytes, and present a byte during WRITE.
  - Words are assembled identically to the first test; each byte is consumed exactly once.
- Reset during DATA after 2 of 4 words: assert reset asynchronously.
  - All outputs return to reset values within the same cycle; cpu_hold=0; no further mem_we.
- Ignored load_req: pulse load_req during HDR1 and again during DATA.
  - No restart; the load completes with the header count unchanged.
